// File: rtl/bitstream_sweep_ctrl.sv
// bitstream_sweep_ctrl: steps a stochastic-bitstream generator input x from
// x_start to x_end (wrapping mod 2^WIDTH), optionally discards a settle
// interval after each x change, counts ones on bit_in over 2^WINDOW_LOG2
// cycles and offers {res_x, res_count} on a valid/ready port.
// Optional feature macro: BITSTREAM_SWEEP_SETTLE_EN (settle interval present).
module bitstream_sweep_ctrl #(
    parameter int WIDTH         = 8,
    parameter int WINDOW_LOG2   = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [WIDTH-1:0]       x_start,
    input  logic [WIDTH-1:0]       x_end,
    input  logic                   bit_in,
    output logic [WIDTH-1:0]       x_out,
    output logic                   busy,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WIDTH-1:0]       res_x,
    output logic [WINDOW_LOG2:0]   res_count,
    output logic                   done
);

`ifdef BITSTREAM_SWEEP_SETTLE_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_COUNT, ST_HOLD} state_t;
    // Every x change re-enters the settle interval first.
    localparam state_t ST_FIRST = ST_SETTLE;
    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    logic [SETTLE_W-1:0] settle_q;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_COUNT, ST_HOLD} state_t;
    localparam state_t ST_FIRST = ST_COUNT;
    // Settle length is meaningless without the settle state.
    logic unused_settle_cfg;
    assign unused_settle_cfg = (SETTLE_CYCLES != 0);
`endif

    state_t                 state_q;
    logic [WIDTH-1:0]       x_out_q;
    logic [WIDTH-1:0]       x_end_q;
    logic [WINDOW_LOG2:0]   cnt_q;
    logic [WINDOW_LOG2-1:0] samp_q;
    logic                   busy_q;
    logic                   res_valid_q;
    logic [WIDTH-1:0]       res_x_q;
    logic [WINDOW_LOG2:0]   res_count_q;
    logic                   done_q;

    logic [WIDTH-1:0]       x_next_d;
    logic [WINDOW_LOG2:0]   cnt_d;

    // Counter is one bit wider than the window index so an all-ones window
    // reaches exactly 2^WINDOW_LOG2 without wrapping.
    assign cnt_d    = cnt_q + {{WINDOW_LOG2{1'b0}}, bit_in};
    assign x_next_d = x_out_q + 1'b1;

    // Sweep sequencer: state, x stepping, window counting and result port.
    // NOTE: all state is assigned with <= so every register updates from
    // the pre-edge values, independent of statement order in this block.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            x_out_q     <= '0;
            x_end_q     <= '0;
            cnt_q       <= '0;
            samp_q      <= '0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_x_q     <= '0;
            res_count_q <= '0;
            done_q      <= 1'b0;
`ifdef BITSTREAM_SWEEP_SETTLE_EN
            settle_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                // Abort wins over start and handshake; x_out keeps its value.
                state_q     <= ST_IDLE;
                busy_q      <= 1'b0;
                res_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            x_out_q  <= x_start;
                            x_end_q  <= x_end;
                            cnt_q    <= '0;
                            samp_q   <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= ST_FIRST;
`ifdef BITSTREAM_SWEEP_SETTLE_EN
                            settle_q <= '0;
`endif
                        end
                    end
`ifdef BITSTREAM_SWEEP_SETTLE_EN
                    ST_SETTLE: begin
                        if (settle_q == SETTLE_LAST) begin
                            state_q <= ST_COUNT;
                        end else begin
                            settle_q <= settle_q + 1'b1;
                        end
                    end
`endif
                    ST_COUNT: begin
                        cnt_q  <= cnt_d;
                        samp_q <= samp_q + 1'b1;
                        if (samp_q == '1) begin
                            res_count_q <= cnt_d;
                            res_x_q     <= x_out_q;
                            res_valid_q <= 1'b1;
                            state_q     <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (res_ready) begin
                            res_valid_q <= 1'b0;
                            if (x_out_q == x_end_q) begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= ST_IDLE;
                            end else begin
                                x_out_q  <= x_next_d;
                                cnt_q    <= '0;
                                samp_q   <= '0;
                                state_q  <= ST_FIRST;
`ifdef BITSTREAM_SWEEP_SETTLE_EN
                                settle_q <= '0;
`endif
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign x_out     = x_out_q;
    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign res_x     = res_x_q;
    assign res_count = res_count_q;
    assign done      = done_q;

endmodule

// File: tb/tb_bitstream_sweep_ctrl.sv
// Self-checking bench for bitstream_sweep_ctrl (default parameters).
// Adapts expected latencies to BITSTREAM_SWEEP_SETTLE_EN.
module tb_bitstream_sweep_ctrl;

`ifdef BITSTREAM_SWEEP_SETTLE_EN
    localparam int S_EFF = 4;
`else
    localparam int S_EFF = 0;
`endif
    localparam int WIN    = 256;
    localparam int BUDGET = 2000;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] x_start = '0;
    logic [7:0] x_end = '0;
    logic       bit_in;
    logic [7:0] x_out;
    logic       busy;
    logic       res_valid;
    logic       res_ready = 1'b1;
    logic [7:0] res_x;
    logic [8:0] res_count;
    logic       done;

    // Bitstream source: 0 = tied low, 1 = tied high, 2 = alternating.
    int   mode = 0;
    logic alt_q = 1'b0;
    assign bit_in = (mode == 2) ? alt_q : (mode == 1);

    typedef struct {
        logic [7:0] x;
        logic [8:0] cnt;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ref_cyc = 0;

    bitstream_sweep_ctrl dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .abort     (abort),
        .x_start   (x_start),
        .x_end     (x_end),
        .bit_in    (bit_in),
        .x_out     (x_out),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_x     (res_x),
        .res_count (res_count),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) alt_q <= ~alt_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Expected results of a whole sweep: ones in a 256-sample window.
    task automatic push_sweep(input logic [7:0] xs, input logic [7:0] xe, input logic [8:0] cnt);
        logic [7:0] x;
        exp_t e;
        x = xs;
        forever begin
            e.x = x;
            e.cnt = cnt;
            exp_q.push_back(e);
            if (x == xe) break;
            x = x + 8'd1;
        end
    endtask

    // Issue start at a negedge; afterwards we sit at the negedge after edge 0.
    task automatic do_start(input logic [7:0] xs, input logic [7:0] xe);
        start = 1'b1;
        x_start = xs;
        x_end = xe;
        @(negedge clk);
        start = 1'b0;
        ref_cyc = cyc;
        check("start_busy", 32'(busy), 1);
        check("start_x_out", 32'(x_out), 32'(xs));
    endtask

    // Wait for a result, score it, complete the handshake and check the
    // follow-up (next x or done pulse). With res_ready low on entry the
    // result is held for 50 cycles first.
    task automatic get_result(input logic [7:0] next_x, input bit last);
        int n;
        exp_t e;
        bit stable;
        logic [7:0] hx;
        logic [8:0] hc;
        logic [7:0] hxo;
        n = 0;
        while (res_valid !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n >= BUDGET) begin
            check("res_valid_timeout", 0, 1);
            return;
        end
        check("res_latency", 32'(cyc - ref_cyc), 32'(S_EFF + WIN));
        if (exp_q.size() == 0) begin
            check("unexpected_result", 1, 0);
            e.x = 'x;
            e.cnt = 'x;
        end else begin
            e = exp_q.pop_front();
        end
        check("res_x", 32'(res_x), 32'(e.x));
        check("res_count", 32'(res_count), 32'(e.cnt));
        if (res_ready !== 1'b1) begin
            hx = res_x;
            hc = res_count;
            hxo = x_out;
            stable = 1'b1;
            repeat (50) begin
                @(negedge clk);
                if (res_valid !== 1'b1 || res_x !== hx || res_count !== hc || x_out !== hxo)
                    stable = 1'b0;
            end
            check("stall_stable", 32'(stable), 1);
            res_ready = 1'b1;
        end
        @(negedge clk);
        ref_cyc = cyc;
        check("after_hs_valid", 32'(res_valid), 0);
        if (last) begin
            check("done_pulse", 32'(done), 1);
            check("done_busy", 32'(busy), 0);
            @(negedge clk);
            check("done_one_cycle", 32'(done), 0);
        end else begin
            check("next_x_out", 32'(x_out), 32'(next_x));
            check("next_busy", 32'(busy), 1);
            check("next_no_done", 32'(done), 0);
        end
    endtask

    initial begin
        bit quiet;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_x_out", 32'(x_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_res_count", 32'(res_count), 0);
        check("rst_done", 32'(done), 0);
        n_rst = 1'b1;
        @(negedge clk);

        // Single point, all ones -> full-scale count.
        mode = 1;
        push_sweep(8'd0, 8'd0, 9'd256);
        do_start(8'd0, 8'd0);
        get_result(8'd0, 1'b1);

        // Three points, all zeros; a start pulse while busy must be ignored.
        mode = 0;
        push_sweep(8'd3, 8'd5, 9'd0);
        do_start(8'd3, 8'd5);
        start = 1'b1;
        x_start = 8'd100;
        x_end = 8'd100;
        @(negedge clk);
        start = 1'b0;
        check("start_ignored_x_out", 32'(x_out), 3);
        get_result(8'd4, 1'b0);
        get_result(8'd5, 1'b0);
        get_result(8'd5, 1'b1);

        // Wrap-around 254..1 with an alternating stream.
        mode = 2;
        push_sweep(8'd254, 8'd1, 9'd128);
        do_start(8'd254, 8'd1);
        get_result(8'd255, 1'b0);
        get_result(8'd0, 1'b0);
        get_result(8'd1, 1'b0);
        get_result(8'd1, 1'b1);

        // Backpressure on the first of two points.
        mode = 1;
        push_sweep(8'd20, 8'd21, 9'd256);
        do_start(8'd20, 8'd21);
        res_ready = 1'b0;
        get_result(8'd21, 1'b0);
        get_result(8'd21, 1'b1);

        // Abort mid-COUNT of the second point of 0..10.
        push_sweep(8'd0, 8'd10, 9'd256);
        do_start(8'd0, 8'd10);
        get_result(8'd1, 1'b0);
        repeat (S_EFF + 100) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_valid", 32'(res_valid), 0);
        check("abort_done", 32'(done), 0);
        check("abort_x_out", 32'(x_out), 1);
        exp_q.delete();
        quiet = 1'b1;
        repeat (300) begin
            @(negedge clk);
            if (done !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        check("abort_stays_idle", 32'(quiet), 1);
        push_sweep(8'd0, 8'd0, 9'd256);
        do_start(8'd0, 8'd0);
        get_result(8'd0, 1'b1);

        // Asynchronous reset shortly after start (mid-SETTLE when present).
        push_sweep(8'd9, 8'd12, 9'd256);
        do_start(8'd9, 8'd12);
        @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        check("arst_x_out", 32'(x_out), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_res_valid", 32'(res_valid), 0);
        check("arst_res_x", 32'(res_x), 0);
        check("arst_res_count", 32'(res_count), 0);
        check("arst_done", 32'(done), 0);
        exp_q.delete();
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        // Single point 7..7, all ones.
        push_sweep(8'd7, 8'd7, 9'd256);
        do_start(8'd7, 8'd7);
        get_result(8'd7, 1'b1);

        check("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
